// File: rtl/axis_traffic_gen_pkg.sv
// Shared definitions for the AXI-Stream traffic generator: FSM encoding, lane width, LFSR polynomial.
// The optional LFSR data pattern is enabled by defining AXIS_TRAFFIC_GEN_LFSR_EN.
package axis_traffic_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam int          LANE_W    = 32;
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  // Right-shifting Galois form: the polynomial taps are XORed in whenever the bit shifted out is 1.
  function automatic logic [31:0] lfsr_step(input logic [31:0] cur);
    lfsr_step = cur[0] ? ((cur >> 1) ^ LFSR_POLY) : (cur >> 1);
  endfunction

endpackage

// File: rtl/axis_traffic_gen_pattern.sv
// Beat data generator: an incrementing lane pattern by default, or a Galois LFSR pattern
// when AXIS_TRAFFIC_GEN_LFSR_EN is defined.
module axis_traffic_gen_pattern
  import axis_traffic_gen_pkg::*;
#(
  parameter int DATA_BYTES = 64
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
  input  logic                    load,
  input  logic [31:0]             seed,
  input  logic                    advance,
  output logic [DATA_BYTES*8-1:0] data
);

  localparam int LANES = DATA_BYTES / 4;

`ifdef AXIS_TRAFFIC_GEN_LFSR_EN
  logic [31:0] r_lfsr;

  // A zero seed would lock the LFSR at zero, so it is forced to 1.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_lfsr <= '0;
    end else if (load) begin
      r_lfsr <= (seed == 32'd0) ? 32'd1 : seed;
    end else if (advance) begin
      r_lfsr <= lfsr_step(r_lfsr);
    end
  end

  always_comb begin
    data = '0;
    for (int i = 0; i < LANES; i++) begin
      data[i*LANE_W +: LANE_W] = r_lfsr ^ 32'(i);
    end
  end
`else
  logic [31:0] r_base;

  // r_base tracks seed + n*LANES for the beat currently offered.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_base <= '0;
    end else if (load) begin
      r_base <= seed;
    end else if (advance) begin
      r_base <= r_base + 32'(LANES);
    end
  end

  always_comb begin
    data = '0;
    for (int i = 0; i < LANES; i++) begin
      data[i*LANE_W +: LANE_W] = r_base + 32'(i);
    end
  end
`endif

endmodule

// File: rtl/axis_traffic_gen.sv
// AXI-Stream reference load source: sends a configured number of patterned beats with a fixed idle gap.
// Define AXIS_TRAFFIC_GEN_LFSR_EN to switch the data pattern to a 32-bit LFSR.
module axis_traffic_gen
  import axis_traffic_gen_pkg::*;
#(
  parameter int DATA_BYTES = 64,
  parameter int COUNT_W    = 64,
  parameter int GAP_W      = 16
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
  input  logic                    cfg_start,
  input  logic                    cfg_stop,
  input  logic [COUNT_W-1:0]      cfg_count,
  input  logic [GAP_W-1:0]        cfg_gap,
  input  logic [31:0]             cfg_seed,
  output logic [DATA_BYTES*8-1:0] m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    busy,
  output logic                    done,
  output logic [COUNT_W-1:0]      beats_sent
);

  state_t               r_state;
  state_t               w_nextState;
  logic [COUNT_W-1:0]   r_count;
  logic [GAP_W-1:0]     r_gap;
  logic [GAP_W-1:0]     r_gapCnt;
  logic [COUNT_W-1:0]   r_beatsSent;
  logic                 r_stopPend;
  logic                 r_done;
  logic                 w_load;
  logic                 w_accept;
  logic                 w_done;
  logic [COUNT_W-1:0]   w_beatsNext;
  logic [DATA_BYTES*8-1:0] w_data;

  assign w_load      = (r_state == ST_IDLE) && cfg_start;
  assign w_accept    = (r_state == ST_SEND) && m_axis_tready;
  assign w_beatsNext = r_beatsSent + COUNT_W'(1);

  // A stop raised in the same cycle as a handshake still lets that beat count before ending.
  always_comb begin
    w_nextState = r_state;
    w_done      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (cfg_start) w_nextState = ST_SEND;
      end
      ST_SEND: begin
        if (w_accept) begin
          if (((r_count != '0) && (w_beatsNext == r_count)) || r_stopPend || cfg_stop) begin
            w_nextState = ST_IDLE;
            w_done      = 1'b1;
          end else if (r_gap != '0) begin
            w_nextState = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (cfg_stop) begin
          w_nextState = ST_IDLE;
          w_done      = 1'b1;
        end else if (r_gapCnt == GAP_W'(1)) begin
          w_nextState = ST_SEND;
        end
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state     <= ST_IDLE;
      r_count     <= '0;
      r_gap       <= '0;
      r_gapCnt    <= '0;
      r_beatsSent <= '0;
      r_stopPend  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_done  <= w_done;
      if (w_load) begin
        r_count     <= cfg_count;
        r_gap       <= cfg_gap;
        r_beatsSent <= '0;
      end else if (w_accept) begin
        r_beatsSent <= w_beatsNext;
      end
      if (w_accept) begin
        r_gapCnt <= r_gap;
      end else if (r_state == ST_GAP) begin
        r_gapCnt <= r_gapCnt - GAP_W'(1);
      end
      if (w_nextState == ST_IDLE) begin
        r_stopPend <= 1'b0;
      end else if ((r_state == ST_SEND) && cfg_stop) begin
        r_stopPend <= 1'b1;
      end
    end
  end

  axis_traffic_gen_pattern #(
    .DATA_BYTES(DATA_BYTES)
  ) u_pattern (
    .ap_clk  (ap_clk),
    .ap_rst_n(ap_rst_n),
    .load    (w_load),
    .seed    (cfg_seed),
    .advance (w_accept),
    .data    (w_data)
  );

  // tvalid comes straight from the state register so an async reset drops it at once.
  assign m_axis_tvalid = (r_state == ST_SEND);
  assign m_axis_tdata  = m_axis_tvalid ? w_data : '0;
  assign busy          = (r_state != ST_IDLE);
  assign done          = r_done;
  assign beats_sent    = r_beatsSent;

endmodule
